pipeline_sequencer: RTL and testbench

//  Parametrised successor to the fixed 4-stage microcode/instruction-data shift chain and clock-enable toggle in the CPU top.

---
 rtl/pipeline_sequencer.sv | 158 +++++++++++++++
 tb/tb_pipeline_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: clock-enable divider, PC owner, N-stage issue pipeline with RAW stall and jump flush.
// Optional stall step counter built only when PIPELINE_SEQ_STALL_COUNT_EN is defined.
module pipeline_sequencer #(
    parameter int STAGES    = 4,
    parameter int MC_W      = 22,
    parameter int DATA_W    = 25,
    parameter int PC_W      = 30,
    parameter int REG_W     = 5,
    parameter int CE_DIV    = 2,
    parameter int JMP_STAGE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     clk_enable,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [MC_W-1:0]          issue_mc,
    input  logic [DATA_W-1:0]        issue_data,
    input  logic [REG_W-1:0]         issue_rs1,
    input  logic [REG_W-1:0]         issue_rs2,
    input  logic [REG_W-1:0]         issue_rd,
    input  logic                     issue_rd_we,
    input  logic                     jmp_valid,
    input  logic [PC_W-1:0]          jmp_addr,
    output logic [PC_W-1:0]          pc,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*MC_W-1:0]   stage_mc,
    output logic [STAGES*DATA_W-1:0] stage_data,
    output logic                     stall,
    output logic [31:0]              stall_cycles
);

    localparam int CE_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [CE_W-1:0] CE_LAST = CE_W'(CE_DIV - 1);

    logic [CE_W-1:0]                 ce_cnt_q, ce_cnt_d;
    logic [PC_W-1:0]                 pc_q, pc_d;
    logic [STAGES-1:0]               valid_q, valid_d;
    logic [STAGES-1:0][MC_W-1:0]     mc_q, mc_d;
    logic [STAGES-1:0][DATA_W-1:0]   data_q, data_d;
    logic [STAGES-1:0][REG_W-1:0]    rd_q, rd_d;
    logic [STAGES-1:0]               rd_we_q, rd_we_d;
    logic                            hazard;

    assign clk_enable = (ce_cnt_q == CE_LAST);

    always_comb begin
        ce_cnt_d = ce_cnt_q + CE_W'(1);
        if (clk_enable) begin
            ce_cnt_d = '0;
        end
    end

    // Last stage writes back this step, so it never blocks an issue.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < STAGES - 1; k++) begin
            if (valid_q[k] && rd_we_q[k] && (rd_q[k] != '0) &&
                ((rd_q[k] == issue_rs1) || (rd_q[k] == issue_rs2))) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard & issue_valid;
    end

    assign stall       = hazard & ~jmp_valid;
    assign issue_ready = clk_enable & ~hazard & ~jmp_valid;

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        mc_d    = mc_q;
        data_d  = data_q;
        rd_d    = rd_q;
        rd_we_d = rd_we_q;
        if (clk_enable) begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                valid_d[k] = valid_q[k-1];
                mc_d[k]    = mc_q[k-1];
                data_d[k]  = data_q[k-1];
                rd_d[k]    = rd_q[k-1];
                rd_we_d[k] = rd_we_q[k-1];
            end
            valid_d[0] = 1'b0;
            mc_d[0]    = '0;
            data_d[0]  = '0;
            rd_d[0]    = '0;
            rd_we_d[0] = 1'b0;
            if (jmp_valid) begin
                pc_d = jmp_addr;
                // Younger instructions behind the jumping one are squashed.
                for (int k = 1; k <= JMP_STAGE; k++) begin
                    valid_d[k] = 1'b0;
                    mc_d[k]    = '0;
                    data_d[k]  = '0;
                    rd_d[k]    = '0;
                    rd_we_d[k] = 1'b0;
                end
            end else if (issue_valid && !hazard) begin
                pc_d       = pc_q + PC_W'(1);
                valid_d[0] = 1'b1;
                mc_d[0]    = issue_mc;
                data_d[0]  = issue_data;
                rd_d[0]    = issue_rd;
                rd_we_d[0] = issue_rd_we;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_cnt_q <= '0;
            pc_q     <= '0;
            valid_q  <= '0;
            mc_q     <= '0;
            data_q   <= '0;
            rd_q     <= '0;
            rd_we_q  <= '0;
        end else begin
            ce_cnt_q <= ce_cnt_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            mc_q     <= mc_d;
            data_q   <= data_d;
            rd_q     <= rd_d;
            rd_we_q  <= rd_we_d;
        end
    end

    assign pc          = pc_q;
    assign stage_valid = valid_q;
    assign stage_mc    = mc_q;
    assign stage_data  = data_q;

`ifdef PIPELINE_SEQ_STALL_COUNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clk_enable && stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: CE timing, streaming, RAW stall,
// x0 exemption, jump flush, mid-run reset and PC wrap.
module tb_pipeline_sequencer;

    localparam int STAGES = 4;
    localparam int MC_W   = 22;
    localparam int DATA_W = 25;
    localparam int PC_W   = 30;
    localparam int REG_W  = 5;

    logic                     clk;
    logic                     rst_n;
    logic                     clk_enable;
    logic                     issue_valid;
    logic                     issue_ready;
    logic [MC_W-1:0]          issue_mc;
    logic [DATA_W-1:0]        issue_data;
    logic [REG_W-1:0]         issue_rs1;
    logic [REG_W-1:0]         issue_rs2;
    logic [REG_W-1:0]         issue_rd;
    logic                     issue_rd_we;
    logic                     jmp_valid;
    logic [PC_W-1:0]          jmp_addr;
    logic [PC_W-1:0]          pc;
    logic [STAGES-1:0]        stage_valid;
    logic [STAGES*MC_W-1:0]   stage_mc;
    logic [STAGES*DATA_W-1:0] stage_data;
    logic                     stall;
    logic [31:0]              stall_cycles;

    int n_tests;
    int n_fail;

    pipeline_sequencer #(
        .STAGES(STAGES), .MC_W(MC_W), .DATA_W(DATA_W), .PC_W(PC_W),
        .REG_W(REG_W), .CE_DIV(3), .JMP_STAGE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_mc(issue_mc), .issue_data(issue_data),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .jmp_valid(jmp_valid), .jmp_addr(jmp_addr), .pc(pc),
        .stage_valid(stage_valid), .stage_mc(stage_mc),
        .stage_data(stage_data), .stall(stall),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Park on the negedge just before the next step.
    task automatic pre_step();
        int n;
        n = 0;
        @(negedge clk);
        while (!clk_enable && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!clk_enable) check("ce_timeout", 64'(clk_enable), 64'd1);
    endtask

    task automatic post_step();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        pre_step();
        post_step();
    endtask

    task automatic offer(input logic [MC_W-1:0] mc, input logic [REG_W-1:0] rs1,
                         input logic [REG_W-1:0] rs2, input logic [REG_W-1:0] rd,
                         input logic we);
        issue_valid = 1'b1;
        issue_mc    = mc;
        issue_data  = DATA_W'(mc) + DATA_W'(1000);
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        issue_rd    = rd;
        issue_rd_we = we;
    endtask

    function automatic logic [MC_W-1:0] mc_at(input int k);
        return stage_mc[k*MC_W +: MC_W];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_sc;
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_mc    = '0;
        issue_data  = '0;
        issue_rs1   = '0;
        issue_rs2   = '0;
        issue_rd    = '0;
        issue_rd_we = 1'b0;
        jmp_valid   = 1'b0;
        jmp_addr    = '0;

        // Reset and clock enable
        repeat (3) @(posedge clk);
        #1;
        check("rst_ce", 64'(clk_enable), 64'd0);
        check("rst_pc", 64'(pc), 64'd0);
        check("rst_valid", 64'(stage_valid), 64'd0);
        check("rst_sc", 64'(stall_cycles), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("ce_edge%0d", i), 64'(clk_enable),
                  64'((i % 3) == 2));
        end
        check("ce_pc", 64'(pc), 64'd0);
        check("ce_valid", 64'(stage_valid), 64'd0);

        // Streaming six independent instructions
        for (int i = 0; i < 6; i++) begin
            offer(MC_W'(100 + i), 5'd0, 5'd0, REG_W'(10 + i), 1'b1);
            pre_step();
            check($sformatf("st_ready%0d", i), 64'(issue_ready), 64'd1);
            post_step();
            check($sformatf("st_pc%0d", i), 64'(pc), 64'(i + 1));
            if (i == 3) check("st_full", 64'(stage_valid), 64'hF);
        end
        issue_valid = 1'b0;
        for (int k = 0; k < 4; k++)
            check($sformatf("st_mc%0d", k), 64'(mc_at(k)), 64'(105 - k));
        check("st_data0", 64'(stage_data[DATA_W-1:0]), 64'd1105);
        repeat (4) step();
        check("st_drain", 64'(stage_valid), 64'd0);

        // RAW stall on rs1
        offer(MC_W'(300), 5'd0, 5'd0, 5'd5, 1'b1);
        step();
        check("raw_pc0", 64'(pc), 64'd7);
        offer(MC_W'(301), 5'd5, 5'd0, 5'd6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pre_step();
            check($sformatf("raw_stall%0d", i), 64'(stall), 64'd1);
            check($sformatf("raw_nrdy%0d", i), 64'(issue_ready), 64'd0);
            post_step();
            check($sformatf("raw_pchold%0d", i), 64'(pc), 64'd7);
        end
        check("raw_valid_pre", 64'(stage_valid), 64'b1000);
        pre_step();
        check("raw_clear", 64'(stall), 64'd0);
        check("raw_rdy", 64'(issue_ready), 64'd1);
        post_step();
        issue_valid = 1'b0;
        check("raw_pc1", 64'(pc), 64'd8);
        check("raw_mc0", 64'(mc_at(0)), 64'd301);
        check("raw_valid", 64'(stage_valid), 64'b0001);
`ifdef PIPELINE_SEQ_STALL_COUNT_EN
        exp_sc = 32'd3;
`else
        exp_sc = 32'd0;
`endif
        check("raw_sc", 64'(stall_cycles), 64'(exp_sc));
        repeat (4) step();

        // x0 destination never causes a hazard
        offer(MC_W'(400), 5'd0, 5'd0, 5'd0, 1'b1);
        step();
        offer(MC_W'(401), 5'd7, 5'd0, 5'd3, 1'b1);
        pre_step();
        check("x0_stall", 64'(stall), 64'd0);
        check("x0_rdy", 64'(issue_ready), 64'd1);
        post_step();
        check("x0_pc", 64'(pc), 64'd10);

        // Jump from stage 1 while a hazarding instruction is offered
        offer(MC_W'(500), 5'd3, 5'd0, 5'd9, 1'b1);
        jmp_valid = 1'b1;
        jmp_addr  = PC_W'(32'h100);
        pre_step();
        check("jmp_nrdy", 64'(issue_ready), 64'd0);
        check("jmp_nstall", 64'(stall), 64'd0);
        post_step();
        jmp_valid = 1'b0;
        check("jmp_pc", 64'(pc), 64'h100);
        check("jmp_valid", 64'(stage_valid), 64'b0100);
        check("jmp_mc1", 64'(mc_at(1)), 64'd0);
        check("jmp_mc2", 64'(mc_at(2)), 64'd400);
        pre_step();
        check("jmp_rdy2", 64'(issue_ready), 64'd1);
        post_step();
        check("jmp_pc2", 64'(pc), 64'h101);
        check("jmp_mc0", 64'(mc_at(0)), 64'd500);

        // Mid-stall asynchronous reset
        offer(MC_W'(600), 5'd9, 5'd0, 5'd1, 1'b0);
        pre_step();
        check("mr_stall", 64'(stall), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_pc", 64'(pc), 64'd0);
        check("mr_valid", 64'(stage_valid), 64'd0);
        check("mr_mc", 64'(stage_mc), 64'd0);
        check("mr_ce", 64'(clk_enable), 64'd0);
        check("mr_stall0", 64'(stall), 64'd0);
        check("mr_sc", 64'(stall_cycles), 64'd0);
        issue_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // PC wrap
        jmp_valid = 1'b1;
        jmp_addr  = '1;
        step();
        jmp_valid = 1'b0;
        check("wrap_top", 64'(pc), 64'h3FFF_FFFF);
        offer(MC_W'(700), 5'd0, 5'd0, 5'd2, 1'b1);
        step();
        issue_valid = 1'b0;
        check("wrap_pc", 64'(pc), 64'd0);
        check("wrap_mc", 64'(mc_at(0)), 64'd700);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
